logic_seq_arbiter: RTL and testbench

- Shares one bit-serial logic datapath between two requesters.
- The datapath is a 1-bit logic unit with 2-bit control, the same function as the team's logicunit.
- Arbitrates with round-robin, captures the winner's W-bit operands and op, evaluates one bit per cycle LSB-first, then returns the W-bit result with a done pulse.
- Sits between requesting lab blocks and the shared logic datapath.

---
 rtl/logic_seq_arbiter.sv | 173 +++++++++++++++++
 tb/tb_logic_seq_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_seq_arbiter.sv
// Round-robin arbiter sharing one bit-serial logic unit between two
// requesters. Optional parity output under LOGIC_SEQ_PARITY_EN.
//
// Ports:
//   clk, reset_n     clock, async active-low reset
//   req[1:0]         level requests, held until done
//   a0,b0,ctl0       requester 0 operands and op
//   a1,b1,ctl1       requester 1 operands and op
//   grant[1:0]       one-hot, acceptance through the done cycle
//   done[1:0]        one-cycle completion pulse
//   result[W-1:0]    last completed result
//   busy             high while RUN/DONE
//   parity           XOR of result (LOGIC_SEQ_PARITY_EN only)
module logic_seq_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [1:0]   ctl0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [1:0]   ctl1,
  output logic [1:0]   grant,
  output logic [1:0]   done,
  output logic [W-1:0] result,
`ifdef LOGIC_SEQ_PARITY_EN
  output logic         parity,
`endif
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t st, st_n;

  logic [1:0]   grant_n, done_n;
  logic [W-1:0] res_n;
  logic         busy_n;
  logic [W-1:0] a_sr, a_n;
  logic [W-1:0] b_sr, b_n;
  logic [W-1:0] r_sr, r_n;
  logic [W:0]   r_cat;
  logic [1:0]   op, op_n;
  logic         last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic         pacc, pacc_n;
  logic         win;
  logic         bit_r;
`ifdef LOGIC_SEQ_PARITY_EN
  logic         par_n;
`endif

  // The shared 1-bit logic unit.
  always_comb begin
    bit_r = 1'b0;
    unique case (op)
      2'd0: bit_r = a_sr[0] & b_sr[0];
      2'd1: bit_r = a_sr[0] | b_sr[0];
      2'd2: bit_r = ~(a_sr[0] | b_sr[0]);
      2'd3: bit_r = a_sr[0] ^ b_sr[0];
      default: bit_r = 1'b0;
    endcase
  end

  // Requester 1 wins alone, or on a tie when 0 was served last.
  assign win = (req == 2'b10) | ((req == 2'b11) & ~last);

  // Concatenation keeps the shift legal for W == 1.
  assign r_cat = {bit_r, r_sr};

  always_comb begin
    st_n    = st;
    grant_n = grant;
    done_n  = 2'b00;
    res_n   = result;
    busy_n  = busy;
    a_n     = a_sr;
    b_n     = b_sr;
    r_n     = r_sr;
    op_n    = op;
    last_n  = last;
    cnt_n   = cnt;
    pacc_n  = pacc;
`ifdef LOGIC_SEQ_PARITY_EN
    par_n   = parity;
`endif
    unique case (st)
      IDLE: begin
        grant_n = 2'b00;
        busy_n  = 1'b0;
        if (|req) begin
          grant_n = win ? 2'b10 : 2'b01;
          last_n  = win;
          a_n     = win ? a1 : a0;
          b_n     = win ? b1 : b0;
          op_n    = win ? ctl1 : ctl0;
          r_n     = '0;
          cnt_n   = '0;
          pacc_n  = 1'b0;
          busy_n  = 1'b1;
          st_n    = RUN;
        end
      end
      RUN: begin
        a_n    = a_sr >> 1;
        b_n    = b_sr >> 1;
        r_n    = r_cat[W:1];
        pacc_n = pacc ^ bit_r;
        cnt_n  = cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          st_n = DONE;
        end
      end
      DONE: begin
        // Grant is held into the done cycle; IDLE drops it.
        res_n  = r_sr;
        done_n = grant;
        busy_n = 1'b0;
`ifdef LOGIC_SEQ_PARITY_EN
        par_n  = pacc;
`endif
        st_n   = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= IDLE;
      grant  <= 2'b00;
      done   <= 2'b00;
      result <= '0;
      busy   <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      op     <= 2'd0;
      last   <= 1'b1;
      cnt    <= '0;
      pacc   <= 1'b0;
`ifdef LOGIC_SEQ_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      st     <= st_n;
      grant  <= grant_n;
      done   <= done_n;
      result <= res_n;
      busy   <= busy_n;
      a_sr   <= a_n;
      b_sr   <= b_n;
      r_sr   <= r_n;
      op     <= op_n;
      last   <= last_n;
      cnt    <= cnt_n;
      pacc   <= pacc_n;
`ifdef LOGIC_SEQ_PARITY_EN
      parity <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_logic_seq_arbiter.sv
// Directed bench for logic_seq_arbiter (W=8).
// Vector table plus hand-written multi-cycle sequences.
module tb_logic_seq_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   ctl0, ctl1;
  logic [1:0]   grant, done;
  logic [W-1:0] result;
  logic         busy;
`ifdef LOGIC_SEQ_PARITY_EN
  logic         parity;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_res;

  always #5 clk = ~clk;

  logic_seq_arbiter #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .a0      (a0),
    .b0      (b0),
    .ctl0    (ctl0),
    .a1      (a1),
    .b1      (b1),
    .ctl1    (ctl1),
    .grant   (grant),
    .done    (done),
    .result  (result),
`ifdef LOGIC_SEQ_PARITY_EN
    .parity  (parity),
`endif
    .busy    (busy)
  );

  typedef struct {
    int           rq;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   ctl;
    logic [W-1:0] exp;
    bit           scramble;
    bit           drop;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full transaction from an idle arbiter.
  task automatic run_op(input vec_t v);
    logic [1:0] oh;
    int n;
    oh = (v.rq == 1) ? 2'b10 : 2'b01;
    if (v.rq == 1) begin
      a1 = v.a; b1 = v.b; ctl1 = v.ctl;
    end else begin
      a0 = v.a; b0 = v.b; ctl0 = v.ctl;
    end
    req = oh;
    @(negedge clk);
    chk("grant_after_req", {30'd0, grant}, {30'd0, oh});
    chk("busy_run", {31'd0, busy}, 32'd1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        n = i;
        break;
      end
      if (i == 5)
        chk("result_held", {24'd0, result}, {24'd0, prev_res});
      if (v.scramble) begin
        if (v.rq == 1) begin
          a1 = W'($urandom); b1 = W'($urandom);
        end else begin
          a0 = W'($urandom); b0 = W'($urandom);
        end
      end
      if (v.drop && i == 4) req = 2'b00;
    end
    chk("done_latency", n, 9);
    chk("done_onehot", {30'd0, done}, {30'd0, oh});
    chk("grant_in_done", {30'd0, grant}, {30'd0, oh});
    chk("result", {24'd0, result}, {24'd0, v.exp});
`ifdef LOGIC_SEQ_PARITY_EN
    chk("parity", {31'd0, parity}, {31'd0, ^v.exp});
`endif
    prev_res = v.exp;
    req = 2'b00;
    @(negedge clk);
    chk("done_pulse_end", {30'd0, done}, 32'd0);
    chk("grant_release", {30'd0, grant}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, 8'hF0, 8'h3C, 2'd3, 8'hCC, 1'b0, 1'b0};
    vecs[1] = '{1, 8'hA5, 8'h0F, 2'd0, 8'h05, 1'b0, 1'b0};
    vecs[2] = '{1, 8'hA5, 8'h0F, 2'd1, 8'hAF, 1'b0, 1'b0};
    vecs[3] = '{1, 8'hA5, 8'h0F, 2'd2, 8'h50, 1'b0, 1'b0};
    vecs[4] = '{1, 8'hA5, 8'h0F, 2'd3, 8'hAA, 1'b0, 1'b0};
    vecs[5] = '{0, 8'h12, 8'h34, 2'd1, 8'h36, 1'b1, 1'b0};
    vecs[6] = '{0, 8'h81, 8'hC3, 2'd0, 8'h81, 1'b1, 1'b1};
    vecs[7] = '{1, 8'hFF, 8'h7F, 2'd3, 8'h80, 1'b0, 1'b1};

    reset_n = 1'b0;
    req = 2'b11;
    a0 = '0; b0 = '0; ctl0 = '0;
    a1 = '0; b1 = '0; ctl1 = '0;
    prev_res = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef LOGIC_SEQ_PARITY_EN
    chk("rst_parity", {31'd0, parity}, 32'd0);
`endif

    req = 2'b00;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_quiet", {19'd0, grant, done, result, busy}, 32'd0);
    end

    foreach (vecs[k]) run_op(vecs[k]);

    // Round-robin with both requests held.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    prev_res = '0;
    a0 = 8'hF0; b0 = 8'h3C; ctl0 = 2'd3;
    a1 = 8'hA5; b1 = 8'h0F; ctl1 = 2'd1;
    req = 2'b11;
    begin
      logic [1:0] pg;
      logic [1:0] exp_g;
      int nacc;
      int last_at;
      int ndone;
      pg = 2'b00;
      exp_g = 2'b01;
      nacc = 0;
      last_at = 0;
      ndone = 0;
      for (int i = 0; i < 45; i++) begin
        @(negedge clk);
        if (grant != 2'b00 && grant != pg) begin
          if (nacc < 4) begin
            chk("rr_grant", {30'd0, grant}, {30'd0, exp_g});
            if (nacc > 0) chk("rr_spacing", i - last_at, 10);
          end
          exp_g = ~exp_g;
          last_at = i;
          nacc++;
        end
        if (done != 2'b00) begin
          ndone++;
          chk("rr_result", {24'd0, result},
              (done == 2'b01) ? 32'hCC : 32'hAF);
        end
        pg = grant;
      end
      chk("rr_accepts", nacc, 5);
      chk("rr_dones", ndone, 4);
    end
    req = 2'b00;
    begin
      int w;
      w = 0;
      while ((grant != 2'b00 || busy) && w < 30) begin
        @(negedge clk);
        w++;
      end
      chk("rr_drain", w < 30, 1);
    end

    // Reset during RUN.
    a0 = 8'h0F; b0 = 8'hFF; ctl0 = 2'd0;
    req = 2'b01;
    @(negedge clk);
    chk("mid_grant", {30'd0, grant}, 32'd1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out", {19'd0, grant, done, result, busy}, 32'd0);
    begin
      bit saw;
      saw = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done != 2'b00) saw = 1'b1;
      end
      chk("mid_no_done", {31'd0, saw}, 32'd0);
    end
    req = 2'b11;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tie", {30'd0, grant}, 32'd1);
    req = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
